seq_det_stream_ctrl: RTL

Controller that sequences the serial sequence detector from a parallel word stream. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word MSB-first onto the detector's serial input, one bit per clock. It samples the detector's Z1/Z2 outputs for every bit driven and counts hits per word. It then returns both counts over a valid/ready result handshake. The block sits between a word-oriented producer/consumer and the single-bit detector, which stays a separate instance.

---
 rtl/seq_det_stream_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-serial controller for the sequence detector: shifts each accepted word
// MSB-first onto det_x and counts detector Z1/Z2 hits for the bits driven.
module seq_det_stream_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_x,
  input  logic             det_z1,
  input  logic             det_z2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_z1_cnt,
  output logic [CNT_W-1:0] out_z2_cnt
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   shreg, shreg_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic               det_x_next;
  logic               out_valid_next;
  logic [CNT_W-1:0]   z1_next, z2_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
    return (hit && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  assign in_ready = (state == IDLE) && !rst;

  // det_x is registered, so the first bit is launched at the accept edge and the
  // shift register holds only the bits still to be driven.
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    idx_next       = idx;
    det_x_next     = 1'b0;
    out_valid_next = out_valid;
    z1_next        = out_z1_cnt;
    z2_next        = out_z2_cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_next = {in_data[WIDTH-2:0], 1'b0};
          det_x_next = in_data[WIDTH-1];
          idx_next   = '0;
          z1_next    = '0;
          z2_next    = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Z reflects the previous bit, so the first SHIFT cycle has nothing to count.
        if (idx != '0) begin
          z1_next = sat_inc(out_z1_cnt, det_z1);
          z2_next = sat_inc(out_z2_cnt, det_z2);
        end
        if (idx == LAST_IDX) begin
          state_next = DRAIN;
        end else begin
          det_x_next = shreg[WIDTH-1];
          shreg_next = {shreg[WIDTH-2:0], 1'b0};
          idx_next   = idx + IDX_W'(1);
        end
      end
      DRAIN: begin
        z1_next        = sat_inc(out_z1_cnt, det_z1);
        z2_next        = sat_inc(out_z2_cnt, det_z2);
        out_valid_next = 1'b1;
        state_next     = REPORT;
      end
      REPORT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      det_x      <= 1'b0;
      out_valid  <= 1'b0;
      out_z1_cnt <= '0;
      out_z2_cnt <= '0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      idx        <= idx_next;
      det_x      <= det_x_next;
      out_valid  <= out_valid_next;
      out_z1_cnt <= z1_next;
      out_z2_cnt <= z2_next;
    end
  end

endmodule
